mips32_instr_fetch: RTL and testbench



---
 rtl/mips32_instr_fetch.sv | 118 +++++++++++
 tb/tb_mips32_instr_fetch.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_instr_fetch.sv
// Instruction fetch stage feeding the single-cycle mips32 core: loadable program memory streamed
// over valid/ready until a zero word or end of memory. Optional debug stepping: MIPS_FETCH_STEP_EN.
module mips32_instr_fetch #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          start,
`ifdef MIPS_FETCH_STEP_EN
    input  logic          step,
`endif
    output logic [31:0]   instr_out,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [31:0]   pc,
    output logic          busy,
    output logic          halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [AW:0]   fptr_reg, fptr_next;
    logic [31:0]   instr_reg, instr_next;
    logic [31:0]   pc_reg, pc_next;
    logic          valid_reg, valid_next;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   fetch_word;
    logic          in_range;
    logic          mem_we;
    logic          adv;
    logic          fire;

    // Program memory is never reset; writes are locked out while streaming.
    assign mem_we = load_en && (state_reg != ST_RUN);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_addr] <= load_data;
        end
    end

    // The MSB of the pointer flags that the whole memory has been consumed.
    assign in_range   = !fptr_reg[AW];
    assign fetch_word = mem[fptr_reg[AW-1:0]];
    assign adv        = !valid_reg || instr_ready;

`ifdef MIPS_FETCH_STEP_EN
    assign fire = adv && step;
`else
    assign fire = adv;
`endif

    always_comb begin
        state_next = state_reg;
        fptr_next  = fptr_reg;
        instr_next = instr_reg;
        pc_next    = pc_reg;
        valid_next = valid_reg;
        case (state_reg)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    state_next = ST_RUN;
                    fptr_next  = '0;
                end
            end
            ST_RUN: begin
                if (fire) begin
                    if (in_range && (fetch_word != 32'd0)) begin
                        instr_next = fetch_word;
                        pc_next    = {{(30-AW){1'b0}}, fptr_reg[AW-1:0], 2'b00};
                        valid_next = 1'b1;
                        fptr_next  = fptr_reg + {{AW{1'b0}}, 1'b1};
                    end else begin
                        // Zero marker or end of memory: the marker itself is never presented.
                        valid_next = 1'b0;
                        state_next = ST_HALT;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            fptr_reg  <= '0;
            instr_reg <= 32'd0;
            pc_reg    <= 32'd0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            fptr_reg  <= fptr_next;
            instr_reg <= instr_next;
            pc_reg    <= pc_next;
            valid_reg <= valid_next;
        end
    end

    assign instr_out   = instr_reg;
    assign instr_valid = valid_reg;
    assign pc          = pc_reg;
    assign busy        = (state_reg == ST_RUN);
    assign halted      = (state_reg == ST_HALT);

endmodule

// File: tb/tb_mips32_instr_fetch.sv
// Self-checking bench for mips32_instr_fetch: a program-order scoreboard built from a memory model,
// directed program/backpressure/reset scenarios and randomized programs with random ready.
module tb_mips32_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = 4'd0;
    logic [31:0] load_data = 32'd0;
    logic        start = 1'b0;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] pc;
    logic        busy;
    logic        halted;
`ifdef MIPS_FETCH_STEP_EN
    logic        step = 1'b1;
`endif

    mips32_instr_fetch #(.DEPTH(16), .AW(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
`ifdef MIPS_FETCH_STEP_EN
        .step        (step),
`endif
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    int          xfer_cnt = 0;
    bit          mon_en = 1'b0;
    bit          step_mode = 1'b0;
    logic [31:0] mdl_mem [16];
    exp_t        exp_q [$];

    logic [31:0] prog [10] = '{32'h00435024, 32'h00435827, 32'h00436025, 32'h00856820,
                               32'h00857021, 32'h00a47822, 32'h00a48023, 32'h0085882b,
                               32'h00c79082, 32'h00c79880};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every transfer must match the next word of the modelled program, and a
    // presented instruction must stay put until it is accepted.
    bit          hold_pending = 1'b0;
    bit          last_pop = 1'b0;
    logic [31:0] held_instr = 32'd0;
    logic [31:0] held_pc = 32'd0;

    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            hold_pending = 1'b0;
            last_pop     = 1'b0;
        end else begin
            if (last_pop && !step_mode) begin
                chk("halt_after_last", {31'd0, halted}, 32'd1);
            end
            last_pop = 1'b0;
            if (hold_pending) begin
                chk("hold_valid", {31'd0, instr_valid}, 32'd1);
                chk("hold_instr", instr_out, held_instr);
                chk("hold_pc", pc, held_pc);
            end
            hold_pending = 1'b0;
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_xfer: got instr %h pc %0d, required no transfer", instr_out, pc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("xfer_instr", instr_out, e.instr);
                    chk("xfer_pc", pc, e.pc);
                    xfer_cnt++;
                    $display("xfer pc=%0d instr=%h", pc, instr_out);
                    if (exp_q.size() == 0) last_pop = 1'b1;
                end
            end else if (instr_valid) begin
                hold_pending = 1'b1;
                held_instr   = instr_out;
                held_pc      = pc;
            end
        end
    end

    task automatic load_word(input int a, input logic [31:0] d);
        load_addr = a[3:0];
        load_data = d;
        load_en   = 1'b1;
        tick();
        load_en   = 1'b0;
        mdl_mem[a] = d;
    endtask

    task automatic build_queue();
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            if (mdl_mem[i] == 32'd0) break;
            exp_q.push_back('{mdl_mem[i], 32'(i * 4)});
        end
    endtask

    // mode: 0 always ready, 1 random ready + ignored loads, 2 backpressure on 0x00856820, 3 stepping
    task automatic run_prog(input int mode, input bit co_load);
        int          n;
        int          cyc;
        int          bp_left;
        bit          bp_done;
        bit          resume_chk;
        logic [31:0] d;
        if (co_load) begin
            d = $urandom;
            if (d == 32'd0) d = 32'd1;
            mdl_mem[0] = d;
            load_addr = 4'd0;
            load_data = d;
            load_en   = 1'b1;
        end
        build_queue();
        n = exp_q.size();
        xfer_cnt   = 0;
        step_mode  = (mode == 3);
        mon_en     = 1'b1;
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start   = 1'b0;
        load_en = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_valid", {31'd0, instr_valid}, 32'd0);
        cyc = 0; bp_left = 0; bp_done = 1'b0; resume_chk = 1'b0;
        while (!halted && cyc < 400) begin
            load_en = 1'b0;
            case (mode)
                1: begin
                    instr_ready = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 7) == 0) begin
                        load_en   = 1'b1;
                        load_addr = 4'($urandom_range(0, 15));
                        load_data = $urandom | 32'd1;
                    end
                end
                2: begin
                    if (bp_left > 0) begin
                        instr_ready = 1'b0;
                    end else if (!bp_done && instr_valid && instr_out == 32'h00856820) begin
                        instr_ready = 1'b0;
                        bp_left = 3;
                        bp_done = 1'b1;
                    end else begin
                        instr_ready = 1'b1;
                    end
                end
                default: instr_ready = 1'b1;
            endcase
`ifdef MIPS_FETCH_STEP_EN
            step = (mode == 3) ? (cyc % 4 == 0) : 1'b1;
`endif
            tick();
            cyc++;
            if (cyc == 1) begin
                chk("first_valid", {31'd0, instr_valid}, (n > 0) ? 32'd1 : 32'd0);
                if (n > 0) begin
                    chk("first_instr", instr_out, mdl_mem[0]);
                    chk("first_pc", pc, 32'd0);
                end
            end
            if (mode == 2 && bp_left > 0) begin
                chk("bp_instr", instr_out, 32'h00856820);
                chk("bp_pc", pc, 32'd12);
                bp_left--;
                if (bp_left == 0) resume_chk = 1'b1;
            end else if (resume_chk) begin
                chk("bp_resume", instr_out, 32'h00857021);
                resume_chk = 1'b0;
            end
        end
        load_en = 1'b0;
`ifdef MIPS_FETCH_STEP_EN
        step = 1'b1;
`endif
        chk("end_halted", {31'd0, halted}, 32'd1);
        chk("end_valid", {31'd0, instr_valid}, 32'd0);
        chk("end_busy", {31'd0, busy}, 32'd0);
        chk("end_xfers", 32'(xfer_cnt), 32'(n));
        if (mode == 0) chk("run_cycles", 32'(cyc), 32'(n + 1));
        if (mode == 3) chk("step_cycles", 32'(cyc), 32'(4 * n + 1));
        if (mode == 2) chk("bp_seen", {31'd0, bp_done}, 32'd1);
        mon_en = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Reference program plus zero fill
        for (int i = 0; i < 16; i++) load_word(i, (i < 10) ? prog[i] : 32'd0);
        build_queue();
        chk("model_len", 32'(exp_q.size()), 32'd10);
        chk("model_last_pc", exp_q[9].pc, 32'd36);
        chk("model_word3", exp_q[3].instr, 32'h00856820);

        run_prog(0, 1'b0);
        run_prog(2, 1'b0);

        // End of memory: all 16 words nonzero, no wrap
        for (int i = 0; i < 16; i++) load_word(i, 32'h00435024 + 32'(i));
        build_queue();
        chk("model_eom_last_pc", exp_q[15].pc, 32'd60);
        run_prog(0, 1'b0);
        run_prog(0, 1'b0);  // restart from HALT

        // Reset mid-run with an ignored write to word 0
        for (int i = 0; i < 10; i++) load_word(i, prog[i]);
        load_word(10, 32'd0);
        build_queue();
        xfer_cnt = 0;
        step_mode = 1'b0;
        mon_en = 1'b1;
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        load_en = 1'b1; load_addr = 4'd0; load_data = 32'hdeadbeef;
        tick();
        load_en = 1'b0;
        for (int k = 0; k < 20 && xfer_cnt < 4; k++) tick();
        chk("mid_xfers", 32'(xfer_cnt), 32'd4);
        mon_en = 1'b0;
        exp_q.delete();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
        chk("midrst_pc", pc, 32'd0);
        chk("midrst_instr", instr_out, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_halted", {31'd0, halted}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_prog(0, 1'b0);
        chk("word0_kept", mdl_mem[0], 32'h00435024);

        // Randomized programs, each followed by a restart that exposes any write leaked during RUN
        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(0, 16);
            for (int i = 0; i < 16; i++) begin
                logic [31:0] d;
                d = $urandom;
                if (d == 32'd0) d = 32'd7;
                load_word(i, (i < len) ? d : 32'd0);
            end
            run_prog(1, r[0]);
            run_prog(0, 1'b0);
        end

`ifdef MIPS_FETCH_STEP_EN
        for (int i = 0; i < 10; i++) load_word(i, prog[i]);
        load_word(10, 32'd0);
        run_prog(3, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
